// File: rtl/lstm_fp_pkg.sv
// Shared float32 constants and FSM state encoding
// for the LSTM gate datapath blocks.
package lstm_fp_pkg;

  localparam int FP_W = 32;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    BIAS,
    DONE
  } mac_state_e;

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational IEEE-754 single-precision adder/subtractor.
// Truncating round; exact cancellation yields +0.
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);

  logic [31:0] b_eff;
  logic [31:0] big;
  logic [31:0] sml;
  logic [7:0]  diff;
  logic [24:0] m_big;
  logic [24:0] m_sml;
  logic [24:0] m_sh;
  logic [24:0] sum;
  logic [4:0]  msb;
  logic [4:0]  lz;
  logic [22:0] norm;
  logic [9:0]  exp_r;

  always_comb begin
    b_eff = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
    Exception = (&a_operand[30:23]) | (&b_operand[30:23]);
    if (a_operand[30:0] >= b_eff[30:0]) begin
      big = a_operand;
      sml = b_eff;
    end else begin
      big = b_eff;
      sml = a_operand;
    end
    diff  = big[30:23] - sml[30:23];
    m_big = {1'b0, |big[30:23], big[22:0]};
    m_sml = {1'b0, |sml[30:23], sml[22:0]};
    m_sh  = (diff > 8'd24) ? 25'd0 : (m_sml >> diff);
    if (big[31] == sml[31]) sum = m_big + m_sh;
    else                    sum = m_big - m_sh;
    msb = 5'd0;
    for (int i = 0; i < 25; i++) begin
      if (sum[i]) msb = 5'(i);
    end
    lz = 5'd23 - msb;
    if (msb == 5'd24) begin
      norm  = sum[23:1];
      exp_r = {2'b0, big[30:23]} + 10'd1;
    end else begin
      norm  = sum[22:0] << lz;
      exp_r = {2'b0, big[30:23]} - {5'd0, lz};
    end
    if (sum == 25'd0) begin
      result = 32'h0;
    end else if (exp_r[9] || exp_r == 10'd0) begin
      result = {big[31], 31'd0};
    end else if (exp_r >= 10'd255) begin
      result = {big[31], 8'hFF, 23'd0};
    end else begin
      result = {big[31], exp_r[7:0], norm};
    end
  end

endmodule

// File: rtl/gate_mac_datapath.sv
// Product/accumulator registers around one multiplier and
// one shared adder; the adder b-operand flips to bias last.
module gate_mac_datapath
  import lstm_fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            take,
  input  logic            fin,
  input  logic [FP_W-1:0] bias,
  input  logic [FP_W-1:0] w,
  input  logic [FP_W-1:0] x,
  output logic [FP_W-1:0] out_data,
  output logic            exc
);

  logic [FP_W-1:0] prod;
  logic [FP_W-1:0] prod_q;
  logic [FP_W-1:0] acc;
  logic [FP_W-1:0] bias_q;
  logic [FP_W-1:0] add_b;
  logic [FP_W-1:0] sum;
  logic            prod_v;
  logic            mul_exc;
  logic            add_exc;
  logic            ovf_unused;
  logic            unf_unused;

  multiplier_fp u_mul (
    .a_operand (w),
    .b_operand (x),
    .Exception (mul_exc),
    .Overflow  (ovf_unused),
    .Underflow (unf_unused),
    .result    (prod)
  );

  always_comb begin
    add_b = prod_q;
    unique case (1'b1)
      fin:     add_b = bias_q;
      default: add_b = prod_q;
    endcase
  end

  Addition_Subtraction u_add (
    .a_operand  (acc),
    .b_operand  (add_b),
    .AddBar_Sub (1'b0),
    .Exception  (add_exc),
    .result     (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= FP_ZERO;
      prod_v   <= 1'b0;
      acc      <= FP_ZERO;
      bias_q   <= FP_ZERO;
      out_data <= FP_ZERO;
      exc      <= 1'b0;
    end else begin
      prod_v <= take;
      if (take) prod_q <= prod;
      if (clr) begin
        acc    <= FP_ZERO;
        bias_q <= bias;
        exc    <= 1'b0;
      end else begin
        if (prod_v) acc <= sum;
        if (fin) out_data <= sum;
        exc <= exc
             | (take & mul_exc)
             | ((prod_v | fin) & add_exc);
      end
    end
  end

endmodule

// File: rtl/multiplier_fp.sv
// Combinational IEEE-754 single-precision multiplier.
// Denormals flush to zero, truncating round.
module multiplier_fp (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic [31:0] result
);

  logic        sign;
  logic        zero;
  logic [23:0] ma;
  logic [23:0] mb;
  logic [24:0] p_hi;
  logic [22:0] p_lo_unused;
  logic [9:0]  exp_s;
  logic [22:0] frac;

  always_comb begin
    sign = a_operand[31] ^ b_operand[31];
    Exception = (&a_operand[30:23]) | (&b_operand[30:23]);
    zero = ~(|a_operand[30:23]) | ~(|b_operand[30:23]);
    ma = {1'b1, a_operand[22:0]};
    mb = {1'b1, b_operand[22:0]};
    {p_hi, p_lo_unused} = ma * mb;
    if (p_hi[24]) begin
      frac  = p_hi[23:1];
      exp_s = {2'b0, a_operand[30:23]}
            + {2'b0, b_operand[30:23]} - 10'd126;
    end else begin
      frac  = p_hi[22:0];
      exp_s = {2'b0, a_operand[30:23]}
            + {2'b0, b_operand[30:23]} - 10'd127;
    end
    Overflow  = 1'b0;
    Underflow = 1'b0;
    if (Exception) begin
      result = {sign, 8'hFF, 23'h40_0000};
    end else if (zero) begin
      result = {sign, 31'd0};
    end else if (exp_s[9] || exp_s == 10'd0) begin
      Underflow = 1'b1;
      result = {sign, 31'd0};
    end else if (exp_s >= 10'd255) begin
      Overflow = 1'b1;
      result = {sign, 8'hFF, 23'd0};
    end else begin
      result = {sign, exp_s[7:0], frac};
    end
  end

endmodule

// File: rtl/gate_preact_mac.sv
// LSTM gate pre-activation: z = sum(w*x) + bias, one pair
// per cycle, result held under a valid/ready handshake.
module gate_preact_mac
  import lstm_fp_pkg::*;
#(
  parameter int N_TERMS = 64,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [FP_W-1:0] bias,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] w,
  input  logic [FP_W-1:0] x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_data,
  output logic            out_exc,
  output logic            busy
);

  mac_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             go;
  logic             take;
  logic             last;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign go        = start && (state == IDLE);
  assign take      = in_valid && in_ready;
  assign last      = take && (cnt == CNT_W'(N_TERMS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      if (go)        cnt <= '0;
      else if (take) cnt <= cnt + CNT_W'(1);
      unique case (state)
        IDLE:    if (start) state <= ACCUM;
        ACCUM:   if (last) state <= DRAIN;
        DRAIN:   state <= BIAS;
        BIAS:    state <= DONE;
        DONE:    if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  gate_mac_datapath u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (go),
    .take     (take),
    .fin      (state == BIAS),
    .bias     (bias),
    .w        (w),
    .x        (x),
    .out_data (out_data),
    .exc      (out_exc)
  );

endmodule
